rom_back: RTL and testbench
===========================

# rom_back

Byte-stream ROM responder sitting at the far end of the ROM command link, opposite the ROM front-end initiator. It pulls command frames from an 8-bit command FIFO, performs aligned reads of a 64-bit-wide synchronous ROM, and pushes response frames into an 8-bit response FIFO. It lets a second FPGA or the host-side bridge serve ROM reads issued through the bus-side front-end.

## Interface
Parameters:
- ROM_AW, 10, ROM word-address width; ROM holds 2^ROM_AW 64-bit words.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_empty  input  1  command FIFO empty.
- cmd_rd_en  output  1  command FIFO pop; data valid on cmd_din the following cycle.
- cmd_din  input  8  command FIFO read data.
- res_full  input  1  response FIFO full.
- res_wr_en  output  1  response FIFO push, one pulse per byte.
- res_dout  output  8  response byte, valid while res_wr_en=1.
- rom_en  output  1  ROM read strobe.
- rom_addr  output  ROM_AW  ROM word address.
- rom_data  input  64  ROM read data, valid one cycle after rom_en.

## Operation
- Command frame, 6 bytes: opcode, addr[7:0], addr[15:8], addr[23:16], addr[31:24], size (log2 of byte count, 0..3).
- Opcode 0x01 = READ. Any other opcode: remaining 5 bytes are still consumed, then status 0xEE is sent with no data.
- Checks after the frame, in this priority order:
  - size > 3 -> 0xE1.
  - Address not aligned to 2^size -> 0xEA.
  - addr[31:3] >= 2^ROM_AW -> 0xEB.
  - Otherwise status 0x00.
- Response frame: status byte. On 0x00 it is followed by 2^size data bytes, least significant first. Data byte k = rom_data[8*(addr[2:0]+k) +: 8].
- States:
  - IDLE -> GET (when !cmd_empty).
  - GET loops for 6 bytes, using a 3-bit byte counter -> CHECK.
  - CHECK -> ROM_REQ on OK, otherwise -> SEND_STAT.
  - ROM_REQ: rom_en=1 for 1 cycle, rom_addr=addr[ROM_AW+2:3] -> ROM_WAIT.
  - ROM_WAIT: latch rom_data into a 64-bit register -> SEND_STAT.
  - SEND_STAT -> SEND_DATA, or [SEND_SUM] / IDLE.
  - SEND_DATA loops for 2^size bytes -> [SEND_SUM] / IDLE.
- Only one frame is in flight at a time. No new command byte is popped until the response has been fully pushed.
- Reset mid-frame: the FSM returns to IDLE and the partial frame is discarded. Bytes already popped are lost; there is no resynchronisation beyond that.

## Timing
- Reset values: cmd_rd_en=0, res_wr_en=0, res_dout=0x00, rom_en=0, rom_addr=0. The state register, counters, address, size and data register all reset to 0.
- cmd_rd_en is asserted only when cmd_empty=0 and is registered. The byte is sampled the cycle after the pop.
  - Back-to-back pops are allowed, so 6 bytes take a minimum of 7 cycles.
- res_wr_en is asserted only in a cycle where res_full=0. If res_full=1, the push stalls with res_dout held and the byte index unchanged.
- ROM latency is fixed at 1 cycle.
- Minimum latency from the last command byte sampled to the status push is 3 cycles for OK frames (CHECK, ROM_REQ, ROM_WAIT) and 1 cycle for error frames.
- Full 8-byte READ with no back-pressure: about 19 cycles from IDLE to IDLE.
- A cmd_empty rise between bytes stalls GET. No timeout.

## Configuration
- ROM_BACK_CHECKSUM_EN:
  - Defined: after the last response byte a SEND_SUM state pushes one extra byte, the XOR of the status byte and all data bytes. It obeys the same res_full stall rules.
  - Undefined: there is no SEND_SUM state and frames end after the status/data bytes.

## Test plan
- ROM word 0 = 0x8877665544332211; command 01 00 00 00 00 03 -> response 00 11 22 33 44 55 66 77 88, plus checksum 0x88 when ROM_BACK_CHECKSUM_EN is defined.
- Command 01 05 00 00 00 00 (byte read at addr 5) -> response 00 66. Command 01 06 00 00 00 01 -> response 00 77 88.
- Command 01 02 00 00 00 02 -> response EA. Command 01 00 20 00 00 00 with ROM_AW=10 -> response EB. Command 01 00 00 00 00 04 -> response E1. Command 7F 00 00 00 00 00 -> response EE. None of these assert rom_en.
- Hold res_full=1 for 5 cycles in the middle of the data bytes -> no push while full, and no byte is lost or duplicated.
- cmd_empty toggles randomly while feeding two frames back to back -> two correct responses in order, and cmd_rd_en is never high while cmd_empty=1.
- Assert rst after 3 command bytes -> all outputs go to their reset values at once. A following complete frame is answered correctly.

Source files
------------

// File: rtl/rom_back.sv
// rom_back: serves 1/2/4/8-byte aligned reads of a 64-bit synchronous ROM over byte-wide command/response FIFOs.
// Define ROM_BACK_CHECKSUM_EN to append an XOR checksum byte (SEND_SUM state) to every response frame.
module rom_back #(
  parameter int ROM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_empty,
  output logic              cmd_rd_en,
  input  logic [7:0]        cmd_din,
  input  logic              res_full,
  output logic              res_wr_en,
  output logic [7:0]        res_dout,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [63:0]       rom_data
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET       = 3'd1,
    S_CHECK     = 3'd2,
    S_ROM_REQ   = 3'd3,
    S_ROM_WAIT  = 3'd4,
    S_SEND_STAT = 3'd5,
`ifdef ROM_BACK_CHECKSUM_EN
    S_SEND_DATA = 3'd6,
    S_SEND_SUM  = 3'd7
`else
    S_SEND_DATA = 3'd6
`endif
  } state_e;

`ifdef ROM_BACK_CHECKSUM_EN
  localparam state_e S_END = S_SEND_SUM;
`else
  localparam state_e S_END = S_IDLE;
`endif

  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_SIZE  = 8'hE1;
  localparam logic [7:0] ST_ALIGN = 8'hEA;
  localparam logic [7:0] ST_RANGE = 8'hEB;
  localparam logic [7:0] ST_OPC   = 8'hEE;

  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] sz);
    case (sz)
      2'd0:    last_idx = 3'd0;
      2'd1:    last_idx = 3'd1;
      2'd2:    last_idx = 3'd3;
      default: last_idx = 3'd7;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic                rd_req_q, rd_req_d;
  logic                got_q, got_d;
  logic [2:0]          pop_cnt_q, pop_cnt_d;
  logic [2:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]          op_q, op_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          size_q, size_d;
  logic [7:0]          status_q, status_d;
  logic [63:0]         data_q, data_d;
  logic [2:0]          idx_q, idx_d;
  logic                rom_en_q, rom_en_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic                push_req_q, push_req_d;
  logic [7:0]          res_dout_q, res_dout_d;
`ifdef ROM_BACK_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic                rd_fire;
  logic                push_fire;
  logic [7:0]          chk_status;
  logic [2:0]          off;

  // Registered requests are gated by the live FIFO flags so no pop/push ever hits an empty/full FIFO.
  assign rd_fire   = rd_req_q & ~cmd_empty;
  assign push_fire = push_req_q & ~res_full;

  assign cmd_rd_en = rd_fire;
  assign res_wr_en = push_fire;
  assign res_dout  = res_dout_q;
  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;

  always_comb begin
    chk_status = ST_OK;
    if (op_q != 8'h01) begin
      chk_status = ST_OPC;
    end else if (size_q > 8'd3) begin
      chk_status = ST_SIZE;
    end else if ((addr_q[2:0] & align_mask(size_q[1:0])) != 3'd0) begin
      chk_status = ST_ALIGN;
    end else if (|addr_q[31:ROM_AW+3]) begin
      chk_status = ST_RANGE;
    end else begin
      chk_status = ST_OK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = cmd_empty ? S_IDLE : S_GET;
      S_GET:       state_d = (got_q && byte_cnt_q == 3'd5) ? S_CHECK : S_GET;
      S_CHECK:     state_d = (chk_status == ST_OK) ? S_ROM_REQ : S_SEND_STAT;
      S_ROM_REQ:   state_d = S_ROM_WAIT;
      S_ROM_WAIT:  state_d = S_SEND_STAT;
      S_SEND_STAT: begin
        if (push_fire) begin
          state_d = (status_q == ST_OK) ? S_SEND_DATA : S_END;
        end else begin
          state_d = S_SEND_STAT;
        end
      end
      S_SEND_DATA: begin
        if (push_fire && idx_q == last_idx(size_q[1:0])) begin
          state_d = S_END;
        end else begin
          state_d = S_SEND_DATA;
        end
      end
`ifdef ROM_BACK_CHECKSUM_EN
      S_SEND_SUM:  state_d = push_fire ? S_IDLE : S_SEND_SUM;
`endif
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_req_d   = rd_req_q;
    got_d      = rd_fire;
    pop_cnt_d  = pop_cnt_q;
    byte_cnt_d = byte_cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    size_d     = size_q;
    status_d   = status_q;
    data_d     = data_q;
    idx_d      = idx_q;
`ifdef ROM_BACK_CHECKSUM_EN
    sum_d      = push_fire ? (sum_q ^ res_dout_q) : sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        pop_cnt_d  = 3'd0;
        byte_cnt_d = 3'd0;
      end
      S_GET: begin
        pop_cnt_d = rd_fire ? (pop_cnt_q + 3'd1) : pop_cnt_q;
        if (got_q) begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          case (byte_cnt_q)
            3'd0:    op_d          = cmd_din;
            3'd1:    addr_d[7:0]   = cmd_din;
            3'd2:    addr_d[15:8]  = cmd_din;
            3'd3:    addr_d[23:16] = cmd_din;
            3'd4:    addr_d[31:24] = cmd_din;
            3'd5:    size_d        = cmd_din;
            default: size_d        = size_q;
          endcase
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
      end
      S_CHECK: begin
        status_d = chk_status;
        idx_d    = 3'd0;
`ifdef ROM_BACK_CHECKSUM_EN
        sum_d    = 8'h00;
`endif
      end
      S_ROM_WAIT:  data_d = rom_data;
      S_SEND_DATA: idx_d  = push_fire ? (idx_q + 3'd1) : idx_q;
      default:     idx_d  = idx_q;
    endcase

    rd_req_d   = (state_d == S_GET) && (pop_cnt_d != 3'd6);
    rom_en_d   = (state_d == S_ROM_REQ);
    rom_addr_d = rom_en_d ? addr_q[ROM_AW+2:3] : rom_addr_q;
    off        = addr_q[2:0] + idx_d;

    // res_dout is loaded with the byte that will be offered in the next cycle.
    case (state_d)
      S_SEND_STAT: begin
        push_req_d = 1'b1;
        res_dout_d = status_d;
      end
      S_SEND_DATA: begin
        push_req_d = 1'b1;
        res_dout_d = data_q[{off, 3'b000} +: 8];
      end
`ifdef ROM_BACK_CHECKSUM_EN
      S_SEND_SUM: begin
        push_req_d = 1'b1;
        res_dout_d = sum_d;
      end
`endif
      default: begin
        push_req_d = 1'b0;
        res_dout_d = res_dout_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_req_q   <= 1'b0;
      got_q      <= 1'b0;
      pop_cnt_q  <= 3'd0;
      byte_cnt_q <= 3'd0;
      op_q       <= 8'h00;
      addr_q     <= 32'h0000_0000;
      size_q     <= 8'h00;
      status_q   <= 8'h00;
      data_q     <= 64'h0;
      idx_q      <= 3'd0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      push_req_q <= 1'b0;
      res_dout_q <= 8'h00;
`ifdef ROM_BACK_CHECKSUM_EN
      sum_q      <= 8'h00;
`endif
    end else begin
      rd_req_q   <= rd_req_d;
      got_q      <= got_d;
      pop_cnt_q  <= pop_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      status_q   <= status_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      push_req_q <= push_req_d;
      res_dout_q <= res_dout_d;
`ifdef ROM_BACK_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_rom_back.sv
// tb_rom_back: table vectors, hand-written corner sequences and random frames checked against a frame-level model.
// Checksum expectations follow ROM_BACK_CHECKSUM_EN exactly as the design build does.
module tb_rom_back;
  localparam int ROM_AW = 10;

  logic              clk, rst;
  logic              cmd_empty, cmd_rd_en;
  logic [7:0]        cmd_din;
  logic              res_full, res_wr_en;
  logic [7:0]        res_dout;
  logic              rom_en;
  logic [ROM_AW-1:0] rom_addr;
  logic [63:0]       rom_data;

  rom_back #(.ROM_AW(ROM_AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_empty(cmd_empty), .cmd_rd_en(cmd_rd_en), .cmd_din(cmd_din),
    .res_full(res_full), .res_wr_en(res_wr_en), .res_dout(res_dout),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [63:0] mem [0:(1<<ROM_AW)-1];
  logic [7:0]  cmd_fifo [$];
  logic [7:0]  res_got [$];
  logic [7:0]  exp_q [$];
  int          exp_rom = 0;
  int          rom_cnt = 0;
  int          res_base = 0;
  int          rom_base = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          stall_at = -1;
  bit          empty_mode = 1'b0;
  bit          full_mode = 1'b0;

  typedef struct packed {
    logic [47:0] cmd;
    logic [3:0]  n;
    logic [71:0] rsp;
    logic [7:0]  sum;
    logic [1:0]  roms;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Frame-level reference: decode the six bytes, apply the error rules, slice the ROM word.
  task automatic model(input logic [7:0] c [6]);
    logic [31:0] a;
    int          sz;
    logic [7:0]  st, b, sum;
    logic [63:0] w;
    a  = {c[4], c[3], c[2], c[1]};
    sz = c[5];
    if (c[0] != 8'h01)                      st = 8'hEE;
    else if (sz > 3)                        st = 8'hE1;
    else if ((a % (32'd1 << sz)) != 32'd0)  st = 8'hEA;
    else if ((a >> 3) >= (32'd1 << ROM_AW)) st = 8'hEB;
    else                                    st = 8'h00;
    exp_q.push_back(st);
    sum = st;
    if (st == 8'h00) begin
      w = mem[a[ROM_AW+2:3]];
      exp_rom++;
      for (int k = 0; k < (1 << sz); k++) begin
        b = 8'((w >> (8 * ((a % 8) + k))) & 64'hFF);
        exp_q.push_back(b);
        sum = sum ^ b;
      end
    end
`ifdef ROM_BACK_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic push_cmd(input logic [7:0] c [6]);
    for (int i = 0; i < 6; i++) cmd_fifo.push_back(c[i]);
  endtask

  task automatic run_check(input string nm);
    int need, budget;
    need   = res_base + exp_q.size();
    budget = 0;
    while (res_got.size() < need && budget < 600) begin
      @(posedge clk);
      budget++;
    end
    repeat (8) @(posedge clk);
    chk({nm, " length"}, 64'(res_got.size() - res_base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (res_base + i < res_got.size())
        chk($sformatf("%s byte%0d", nm, i), res_got[res_base + i], exp_q[i]);
    end
    chk({nm, " rom reads"}, 64'(rom_cnt - rom_base), 64'(exp_rom));
    res_base = res_got.size();
    rom_base = rom_cnt;
    exp_q.delete();
    exp_rom = 0;
  endtask

  // FIFO/ROM/sink models: sample DUT at negedge, apply effects and new flags 1 time unit after posedge.
  initial begin
    int         stall_left = 0;
    int         stall_seen = -1;
    logic       s_rd, s_wr, s_rom;
    logic [7:0] s_dout, held;
    logic [ROM_AW-1:0] s_addr;
    cmd_empty = 1'b1;
    cmd_din   = 8'h00;
    res_full  = 1'b0;
    rom_data  = 64'h0;
    held      = 8'h00;
    forever begin
      @(negedge clk);
      s_rd = cmd_rd_en; s_wr = res_wr_en; s_dout = res_dout; s_rom = rom_en; s_addr = rom_addr;
      if (s_rd) chk("pop_while_empty", 64'(cmd_empty), 64'd0);
      if (s_wr) chk("push_while_full", 64'(res_full), 64'd0);
      if (stall_left == 5) held = s_dout;
      else if (stall_left > 0) chk("stall_dout_held", s_dout, held);
      @(posedge clk);
      #1;
      if (stall_left > 0) stall_left--;
      if (s_rd && cmd_fifo.size() > 0) cmd_din = cmd_fifo.pop_front();
      if (s_rom) begin
        rom_data = mem[s_addr];
        rom_cnt++;
      end
      if (s_wr) res_got.push_back(s_dout);
      if (stall_at >= 0 && stall_at != stall_seen && res_got.size() == stall_at) begin
        stall_left = 5;
        stall_seen = stall_at;
      end
      res_full  = (stall_left > 0) || (full_mode && $urandom_range(0, 2) == 0);
      cmd_empty = (cmd_fifo.size() == 0) || (empty_mode && $urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c [6];
    logic [31:0] a;
    int sz;
    logic [2:0] off;

    for (int i = 0; i < (1 << ROM_AW); i++) mem[i] = {$urandom(), $urandom()};
    mem[0]    = 64'h8877665544332211;
    mem[1]    = 64'hF1E2D3C4B5A69788;
    mem[1023] = 64'h0123456789ABCDEF;

    vecs[0] = '{48'h03_00_00_00_00_01, 4'd9, 72'h88_77_66_55_44_33_22_11_00, 8'h88, 2'd1};
    vecs[1] = '{48'h00_00_00_00_05_01, 4'd2, 72'h66_00, 8'h66, 2'd1};
    vecs[2] = '{48'h01_00_00_00_06_01, 4'd3, 72'h88_77_00, 8'hFF, 2'd1};
    vecs[3] = '{48'h02_00_00_00_02_01, 4'd1, 72'hEA, 8'hEA, 2'd0};
    vecs[4] = '{48'h00_00_00_20_00_01, 4'd1, 72'hEB, 8'hEB, 2'd0};
    vecs[5] = '{48'h04_00_00_00_00_01, 4'd1, 72'hE1, 8'hE1, 2'd0};
    vecs[6] = '{48'h00_00_00_00_00_7F, 4'd1, 72'hEE, 8'hEE, 2'd0};
    vecs[7] = '{48'h03_00_00_1F_F8_01, 4'd9, 72'h01_23_45_67_89_AB_CD_EF_00, 8'h00, 2'd1};
    vecs[8] = '{48'h02_00_00_00_04_01, 4'd5, 72'h88_77_66_55_00, 8'hCC, 2'd1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset cmd_rd_en", 64'(cmd_rd_en), 64'd0);
    chk("reset res_wr_en", 64'(res_wr_en), 64'd0);
    chk("reset res_dout", 64'(res_dout), 64'h00);
    chk("reset rom_en", 64'(rom_en), 64'd0);
    chk("reset rom_addr", 64'(rom_addr), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 6; i++) c[i] = vecs[v].cmd[8*i +: 8];
      for (int i = 0; i < int'(vecs[v].n); i++) exp_q.push_back(vecs[v].rsp[8*i +: 8]);
`ifdef ROM_BACK_CHECKSUM_EN
      exp_q.push_back(vecs[v].sum);
`endif
      exp_rom = int'(vecs[v].roms);
      push_cmd(c);
      run_check($sformatf("vec%0d", v));
    end

    // Back-pressure for 5 cycles after the status and three data bytes.
    stall_at = res_base + 4;
    c[0] = 8'h01; c[1] = 8'h00; c[2] = 8'h00; c[3] = 8'h00; c[4] = 8'h00; c[5] = 8'h03;
    model(c);
    push_cmd(c);
    run_check("stall");

    // Two frames queued together while cmd_empty flickers.
    empty_mode = 1'b1;
    c[0] = 8'h01; c[1] = 8'h10; c[2] = 8'h00; c[3] = 8'h00; c[4] = 8'h00; c[5] = 8'h03;
    model(c);
    push_cmd(c);
    c[1] = 8'h1B; c[5] = 8'h00;
    model(c);
    push_cmd(c);
    run_check("b2b");

    for (int f = 0; f < 30; f++) begin
      sz  = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 255) : $urandom_range(0, 3);
      off = 3'($urandom_range(0, 7));
      if (sz < 4 && $urandom_range(0, 3) != 0) off = off & 3'(~((1 << sz) - 1));
      a = (32'($urandom_range(0, 1023)) << 3) | 32'(off);
      if ($urandom_range(0, 9) == 0) a = $urandom();
      c[0] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'h01;
      c[1] = a[7:0]; c[2] = a[15:8]; c[3] = a[23:16]; c[4] = a[31:24];
      c[5] = 8'(sz);
      empty_mode = 1'($urandom_range(0, 1));
      full_mode  = 1'($urandom_range(0, 1));
      model(c);
      push_cmd(c);
      run_check($sformatf("rand%0d", f));
    end

    // Reset in the middle of a frame, after a read that leaves rom_addr and res_dout non-zero.
    empty_mode = 1'b0;
    full_mode  = 1'b0;
    c[0] = 8'h01; c[1] = 8'h08; c[2] = 8'h00; c[3] = 8'h00; c[4] = 8'h00; c[5] = 8'h03;
    model(c);
    push_cmd(c);
    run_check("pre_reset");
    cmd_fifo.push_back(8'h01);
    cmd_fifo.push_back(8'h00);
    cmd_fifo.push_back(8'h00);
    for (int t = 0; t < 50 && cmd_fifo.size() > 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midreset cmd_rd_en", 64'(cmd_rd_en), 64'd0);
    chk("midreset res_wr_en", 64'(res_wr_en), 64'd0);
    chk("midreset res_dout", 64'(res_dout), 64'h00);
    chk("midreset rom_en", 64'(rom_en), 64'd0);
    chk("midreset rom_addr", 64'(rom_addr), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (4) @(posedge clk);
    chk("midreset no response", 64'(res_got.size() - res_base), 64'd0);
    c[0] = 8'h01; c[1] = 8'h05; c[2] = 8'h00; c[3] = 8'h00; c[4] = 8'h00; c[5] = 8'h00;
    model(c);
    push_cmd(c);
    run_check("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
